vram_arbiter: RTL and testbench

Shares the single-port video RAM between the scanline fetch path feeding the 640x480 video signal generator and the Hack CPU's screen-memory port. Video reads have priority so that no pixel word arrives late. A starvation counter guarantees the CPU a slot within a bounded number of cycles. Read data is routed back to the correct requester through a latency-matched ownership pipeline.

---
 rtl/vram_arbiter_if.sv | 40 ++++
 rtl/vram_arbiter.sv | 113 +++++++++++
 tb/tb_vram_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// Request, response and memory-command bundle for vram_arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface vram_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  vid_req;
  logic [ADDR_WIDTH-1:0] vid_addr;
  logic                  vid_ack;
  logic                  vid_rvalid;
  logic [DATA_WIDTH-1:0] vid_rdata;

  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_ack;
  logic                  cpu_rvalid;
  logic [DATA_WIDTH-1:0] cpu_rdata;

  logic                  vid_blank;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_blank, mem_rdata,
    output vid_ack, vid_rvalid, vid_rdata, cpu_ack, cpu_rvalid, cpu_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_blank, mem_rdata,
    input  vid_ack, vid_rvalid, vid_rdata, cpu_ack, cpu_rvalid, cpu_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video reads have priority, CPU is protected by a
// starvation counter, and read data is routed back via an ownership pipeline.
module vram_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 13,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic           clk,
  input logic           reset,
  vram_arbiter_if.slave bus
);

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  logic                  vid_grant;
  logic                  cpu_grant;
  logic                  rd_grant;

  logic [3:0]            starve_q, starve_d;

  logic                  en_q, en_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  // Index 0 is the entry inserted at the grant edge; index READ_LATENCY lines
  // up with the cycle in which mem_rdata carries that access's data.
  logic [READ_LATENCY:0] pipe_valid_q, pipe_valid_d;
  logic [READ_LATENCY:0] pipe_owner_q, pipe_owner_d;

  // Grant decision; acks are forced low while reset is asserted.
  always_comb begin
    vid_grant = 1'b0;
    cpu_grant = 1'b0;
    if (!reset) begin
      if (bus.cpu_req && (!bus.vid_req || bus.vid_blank || (starve_q == StarveMax))) begin
        cpu_grant = 1'b1;
      end else if (bus.vid_req) begin
        vid_grant = 1'b1;
      end
    end
  end

  assign rd_grant = vid_grant || (cpu_grant && !bus.cpu_we);

  always_comb begin
    starve_d = starve_q;
    if (cpu_grant || !bus.cpu_req) begin
      starve_d = 4'd0;
    end else if (vid_grant && (starve_q != StarveMax)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Command register: the winner's fields are latched; video never writes and
  // leaves the write-data field untouched.
  always_comb begin
    en_d    = 1'b0;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (cpu_grant) begin
      en_d    = 1'b1;
      we_d    = bus.cpu_we;
      addr_d  = bus.cpu_addr;
      wdata_d = bus.cpu_wdata;
    end else if (vid_grant) begin
      en_d   = 1'b1;
      we_d   = 1'b0;
      addr_d = bus.vid_addr;
    end
  end

  always_comb begin
    pipe_valid_d = {pipe_valid_q[READ_LATENCY-1:0], rd_grant};
    pipe_owner_d = {pipe_owner_q[READ_LATENCY-1:0], cpu_grant};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q     <= 4'd0;
      en_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      pipe_valid_q <= '0;
      pipe_owner_q <= '0;
    end else begin
      starve_q     <= starve_d;
      en_q         <= en_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_owner_q <= pipe_owner_d;
    end
  end

  assign bus.vid_ack    = vid_grant;
  assign bus.cpu_ack    = cpu_grant;

  assign bus.mem_en     = en_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;

  assign bus.vid_rvalid = pipe_valid_q[READ_LATENCY] && !pipe_owner_q[READ_LATENCY];
  assign bus.cpu_rvalid = pipe_valid_q[READ_LATENCY] &&  pipe_owner_q[READ_LATENCY];
  assign bus.vid_rdata  = bus.mem_rdata;
  assign bus.cpu_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench: three arbiters (READ_LATENCY 1, 2, 3) share one stimulus set,
// each with its own behavioural VRAM; each test checks the instance it targets.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vid_req = 1'b0;
  logic [12:0] vid_addr = '0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [12:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        vid_blank = 1'b0;

  logic [3:1]  vid_ack_w, cpu_ack_w, vid_rv_w, cpu_rv_w, mem_en_w, mem_we_w;
  logic [12:0] mem_addr_w  [1:3];
  logic [15:0] mem_wdata_w [1:3];
  logic [15:0] vid_rdata_w [1:3];
  logic [15:0] cpu_rdata_w [1:3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 1; g <= 3; g++) begin : g_dut
    vram_arbiter_if #(.ADDR_WIDTH(13), .DATA_WIDTH(16)) bus ();

    logic [15:0]   mem [0:8191];
    logic [8191:0] written = '0;
    logic [15:0]   rd_pipe [0:g-1];

    assign bus.vid_req   = vid_req;
    assign bus.vid_addr  = vid_addr;
    assign bus.cpu_req   = cpu_req;
    assign bus.cpu_we    = cpu_we;
    assign bus.cpu_addr  = cpu_addr;
    assign bus.cpu_wdata = cpu_wdata;
    assign bus.vid_blank = vid_blank;
    assign bus.mem_rdata = rd_pipe[g-1];

    // Unwritten words read back as addr ^ 0xA5A5.
    always @(posedge clk) begin
      if (bus.mem_en && bus.mem_we) begin
        mem[bus.mem_addr]     <= bus.mem_wdata;
        written[bus.mem_addr] <= 1'b1;
      end
      if (bus.mem_en && !bus.mem_we) begin
        rd_pipe[0] <= written[bus.mem_addr] ? mem[bus.mem_addr]
                                            : ({3'b000, bus.mem_addr} ^ 16'hA5A5);
      end else begin
        rd_pipe[0] <= 16'hDEAD;
      end
      for (int i = 1; i < g; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    vram_arbiter #(
      .ADDR_WIDTH  (13),
      .DATA_WIDTH  (16),
      .READ_LATENCY(g),
      .STARVE_LIMIT(4)
    ) u_dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
    );

    assign vid_ack_w[g]   = bus.vid_ack;
    assign cpu_ack_w[g]   = bus.cpu_ack;
    assign vid_rv_w[g]    = bus.vid_rvalid;
    assign cpu_rv_w[g]    = bus.cpu_rvalid;
    assign mem_en_w[g]    = bus.mem_en;
    assign mem_we_w[g]    = bus.mem_we;
    assign mem_addr_w[g]  = bus.mem_addr;
    assign mem_wdata_w[g] = bus.mem_wdata;
    assign vid_rdata_w[g] = bus.vid_rdata;
    assign cpu_rdata_w[g] = bus.cpu_rdata;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      vid_req   = 1'b0;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      vid_blank = 1'b0;
    end
  endtask

  task automatic test_reset();
    vid_req = 1'b1;
    cpu_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({vid_ack_w, cpu_ack_w} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_acks: got %b expected 000000", {vid_ack_w, cpu_ack_w});
    end
    n_checks++;
    if ({vid_rv_w, cpu_rv_w} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_rvalid: got %b expected 000000", {vid_rv_w, cpu_rv_w});
    end
    n_checks++;
    if ({mem_en_w, mem_we_w} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_mem_en_we: got %b expected 000000", {mem_en_w, mem_we_w});
    end
    n_checks++;
    if (mem_addr_w[1] !== 13'h0 || mem_wdata_w[1] !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_mem_addr_wdata: got %h/%h expected 0000/0000",
               mem_addr_w[1], mem_wdata_w[1]);
    end
    next_cycle();
    vid_req = 1'b0;
    cpu_req = 1'b0;
    reset   = 1'b0;
    idle(2);
  endtask

  // RL=1 instance: CPU read of 0x0100.
  task automatic test_single_read();
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      cpu_req  = (c == 0);
      cpu_we   = 1'b0;
      cpu_addr = 13'h0100;
      @(negedge clk);
      n_checks++;
      if (cpu_ack_w[1] !== (c == 0)) begin
        n_fail++;
        $display("FAIL single_cpu_ack c%0d: got %b expected %b", c, cpu_ack_w[1], c == 0);
      end
      n_checks++;
      if (vid_rv_w[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL single_vid_rvalid c%0d: got %b expected 0", c, vid_rv_w[1]);
      end
      n_checks++;
      if (cpu_rv_w[1] !== (c == 2)) begin
        n_fail++;
        $display("FAIL single_cpu_rvalid c%0d: got %b expected %b", c, cpu_rv_w[1], c == 2);
      end
      if (c == 1) begin
        n_checks++;
        if (mem_en_w[1] !== 1'b1 || mem_we_w[1] !== 1'b0 || mem_addr_w[1] !== 13'h0100) begin
          n_fail++;
          $display("FAIL single_cmd: got en=%b we=%b addr=%h expected en=1 we=0 addr=0100",
                   mem_en_w[1], mem_we_w[1], mem_addr_w[1]);
        end
      end
      if (c == 2) begin
        n_checks++;
        if (cpu_rdata_w[1] !== 16'hA4A5) begin
          n_fail++;
          $display("FAIL single_cpu_rdata: got %h expected a4a5", cpu_rdata_w[1]);
        end
      end
    end
    idle(2);
  endtask

  // RL=1 instance: continuous video, CPU write waits at most STARVE_LIMIT grants.
  task automatic test_starvation();
    logic pending = 1'b1;
    for (int c = 0; c < 7; c++) begin
      next_cycle();
      vid_req   = 1'b1;
      vid_addr  = 13'(13'h0400 + c);
      cpu_req   = pending;
      cpu_we    = 1'b1;
      cpu_addr  = 13'h1FFF;
      cpu_wdata = 16'hBEEF;
      @(negedge clk);
      n_checks++;
      if (vid_ack_w[1] !== (c != 4) || cpu_ack_w[1] !== (c == 4)) begin
        n_fail++;
        $display("FAIL starve_acks c%0d: got vid=%b cpu=%b expected vid=%b cpu=%b",
                 c, vid_ack_w[1], cpu_ack_w[1], c != 4, c == 4);
      end
      if (cpu_ack_w[1] === 1'b1) pending = 1'b0;
    end
    idle(3);
    n_checks++;
    if (g_dut[1].mem[13'h1FFF] !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL starve_mem_write: got %h expected beef", g_dut[1].mem[13'h1FFF]);
    end
  endtask

  // RL=2 instance: blanking hands every slot to the CPU.
  task automatic test_blanking();
    for (int c = 0; c < 7; c++) begin
      next_cycle();
      vid_req   = 1'b1;
      vid_addr  = 13'h0010;
      cpu_req   = 1'b1;
      cpu_we    = 1'b1;
      cpu_addr  = 13'h0050;
      cpu_wdata = 16'h1234;
      vid_blank = (c < 5);
      @(negedge clk);
      n_checks++;
      if (cpu_ack_w[2] !== (c < 5) || vid_ack_w[2] !== (c >= 5)) begin
        n_fail++;
        $display("FAIL blank_acks c%0d: got vid=%b cpu=%b expected vid=%b cpu=%b",
                 c, vid_ack_w[2], cpu_ack_w[2], c >= 5, c < 5);
      end
    end
    idle(4);
  endtask

  // RL=3 instance: alternating reads then a write; rvalid 4 cycles after grant.
  task automatic test_interleaved();
    logic        exp_v [0:15];
    logic        exp_c [0:15];
    logic [15:0] exp_d [0:15];
    for (int i = 0; i < 16; i++) begin
      exp_v[i] = 1'b0;
      exp_c[i] = 1'b0;
      exp_d[i] = 16'h0;
    end
    for (int k = 0; k < 8; k++) begin
      exp_v[k+4] = 1'b1;
      exp_c[k+4] = (k % 2 == 1);
      exp_d[k+4] = (k % 2 == 1) ? (16'(16'h0300 + k) ^ 16'hA5A5)
                                : (16'(16'h0200 + k) ^ 16'hA5A5);
    end
    for (int c = 0; c < 15; c++) begin
      next_cycle();
      vid_req   = (c < 8) && (c % 2 == 0);
      vid_addr  = 13'(13'h0200 + c);
      cpu_req   = ((c < 8) && (c % 2 == 1)) || (c == 8);
      cpu_we    = (c == 8);
      cpu_addr  = (c == 8) ? 13'h0060 : 13'(13'h0300 + c);
      cpu_wdata = 16'h5A5A;
      @(negedge clk);
      n_checks++;
      if (vid_rv_w[3] !== (exp_v[c] && !exp_c[c]) || cpu_rv_w[3] !== (exp_v[c] && exp_c[c])) begin
        n_fail++;
        $display("FAIL inter_rvalid c%0d: got vid=%b cpu=%b expected vid=%b cpu=%b", c,
                 vid_rv_w[3], cpu_rv_w[3], exp_v[c] && !exp_c[c], exp_v[c] && exp_c[c]);
      end
      if (exp_v[c]) begin
        n_checks++;
        if ((exp_c[c] ? cpu_rdata_w[3] : vid_rdata_w[3]) !== exp_d[c]) begin
          n_fail++;
          $display("FAIL inter_rdata c%0d: got %h expected %h", c,
                   exp_c[c] ? cpu_rdata_w[3] : vid_rdata_w[3], exp_d[c]);
        end
      end
    end
    idle(3);
  endtask

  // RL=2 instance: reset one cycle after a read grant, released two cycles later.
  task automatic test_reset_midflight();
    for (int c = 0; c < 9; c++) begin
      next_cycle();
      vid_req   = (c < 8);
      vid_addr  = 13'h00AA;
      cpu_req   = (c < 8);
      cpu_we    = 1'b1;
      cpu_addr  = 13'h0070;
      cpu_wdata = 16'h7777;
      if (c == 1) begin
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if ({vid_ack_w[2], cpu_ack_w[2], vid_rv_w[2], cpu_rv_w[2], mem_en_w[2], mem_we_w[2]}
            !== 6'b0) begin
          n_fail++;
          $display("FAIL midreset_flags: got %b expected 000000", {vid_ack_w[2], cpu_ack_w[2],
                   vid_rv_w[2], cpu_rv_w[2], mem_en_w[2], mem_we_w[2]});
        end
        n_checks++;
        if (mem_addr_w[2] !== 13'h0 || mem_wdata_w[2] !== 16'h0) begin
          n_fail++;
          $display("FAIL midreset_addr_wdata: got %h/%h expected 0000/0000",
                   mem_addr_w[2], mem_wdata_w[2]);
        end
      end
      if (c == 3) #1 reset = 1'b0;
      @(negedge clk);
      if (c == 0 || c >= 3) begin
        n_checks++;
        if (vid_ack_w[2] !== (c <= 6) || cpu_ack_w[2] !== (c == 7)) begin
          n_fail++;
          $display("FAIL midreset_acks c%0d: got vid=%b cpu=%b expected vid=%b cpu=%b",
                   c, vid_ack_w[2], cpu_ack_w[2], c <= 6, c == 7);
        end
      end
      if (c >= 3) begin
        n_checks++;
        if (vid_rv_w[2] !== (c == 6 || c == 7 || c == 8) || cpu_rv_w[2] !== 1'b0) begin
          n_fail++;
          $display("FAIL midreset_rvalid c%0d: got vid=%b cpu=%b expected vid=%b cpu=0",
                   c, vid_rv_w[2], cpu_rv_w[2], c == 6 || c == 7 || c == 8);
        end
      end
    end
    idle(3);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_starvation();
    test_blanking();
    test_interleaved();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
